// File: rtl/ula_arbiter.sv
// Two-requester arbiter sharing one fixed-latency ULA: round-robin grant on ties,
// issue operands, wait out the latency, then hand the captured result back to the owner.
module ula_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ULA_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [3:0]         req_op,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [WIDTH-1:0]   resp_result,
  output logic [WIDTH-1:0]   ula_a,
  output logic [WIDTH-1:0]   ula_b,
  output logic [1:0]         ula_op,
  input  logic [WIDTH-1:0]   ula_result,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT4 = 4'(ULA_LAT);

  state_t     state, state_nxt;
  logic       owner;
  logic       rr_last;
  logic [3:0] cnt;
  logic [1:0] grant;
  logic       acc_i;

  // Grant is only offered in IDLE; a tie goes to whoever was not served last.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign acc_i     = grant[1];
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    resp_valid = 2'b00;
    case (state)
      IDLE: if (|grant) state_nxt = EXEC;
      EXEC: if (cnt == 4'd1) state_nxt = RESP;
      RESP: begin
        resp_valid = owner ? 2'b10 : 2'b01;
        if (resp_ready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ula_a       <= '0;
      ula_b       <= '0;
      ula_op      <= '0;
      resp_result <= '0;
      owner       <= 1'b0;
      rr_last     <= 1'b1;
      cnt         <= '0;
    end else begin
      state <= state_nxt;
      if (|grant) begin
        ula_a   <= acc_i ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
        ula_b   <= acc_i ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
        ula_op  <= acc_i ? req_op[3:2] : req_op[1:0];
        owner   <= acc_i;
        rr_last <= acc_i;
        cnt     <= LAT4;
      end
      // Operands stay put through EXEC; result is sampled on the last latency edge.
      if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) resp_result <= ula_result;
      end
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: two instances (latency 1 and 3) with an adder stub ULA,
// directed scenarios then random traffic, all checked against a transaction-level model.
module tb_ula_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         rst;
  logic [1:0][1:0]    rv, rdy, rsv, rr, uop;
  logic [1:0][63:0]   ra, rb;
  logic [1:0][3:0]    rop;
  logic [1:0][W-1:0]  rres, ua, ub, ures;
  logic [1:0]         bsy;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    ula_arbiter #(.WIDTH(W), .ULA_LAT(L)) u_dut (
      .clk(clk), .rst_n(rst[g]), .req_valid(rv[g]), .req_ready(rdy[g]),
      .req_a(ra[g]), .req_b(rb[g]), .req_op(rop[g]), .resp_valid(rsv[g]),
      .resp_ready(rr[g]), .resp_result(rres[g]), .ula_a(ua[g]), .ula_b(ub[g]),
      .ula_op(uop[g]), .ula_result(ures[g]), .busy(bsy[g]));
    // Stub ULA: a+b; the arbiter's operand register is the first of the L stages.
    if (L == 1) begin : g_comb
      assign ures[g] = ua[g] + ub[g];
    end else begin : g_pipe
      logic [L-2:0][W-1:0] pipe;
      always_ff @(posedge clk) begin
        pipe[0] <= ua[g] + ub[g];
        for (int k = 1; k < L - 1; k++) pipe[k] <= pipe[k-1];
      end
      assign ures[g] = pipe[L-2];
    end
  end

  typedef struct {int d; int own; logic [W-1:0] res; int acc; int done;} log_t;
  log_t lg[$];

  int checks = 0, errors = 0, cyc = 0;
  int lat[2] = '{1, 3};
  bit infl[2], fresh[2];
  int acc[2], own[2], last[2], obs_acc[2];
  logic [W-1:0] ev[2], ea[2], eb[2];
  logic [1:0] eo[2];

  task automatic chk(int d, string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL dut%0d %s: got %0h want %0h", d, tag, o, e);
    end
  endtask

  function automatic logic [1:0] grant(logic [1:0] v, int lst);
    if (v == 2'b11) return (lst == 0) ? 2'b10 : 2'b01;
    return v;
  endfunction

  // Result is due ULA_LAT+1 edges after the accept edge and stays until consumed.
  function automatic logic [1:0] exp_resp(int d);
    if (infl[d] && cyc >= acc[d] + lat[d] + 1) return (own[d] == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic check_dut(int d);
    logic [1:0] er;
    er = exp_resp(d);
    chk(d, "req_ready", rdy[d], infl[d] ? 2'b00 : grant(rv[d], last[d]));
    chk(d, "resp_valid", rsv[d], er);
    chk(d, "busy", bsy[d], infl[d]);
    if (er != 0) chk(d, "resp_result", rres[d], ev[d]);
    if (fresh[d]) begin
      chk(d, "ula_a_rst", ua[d], 0);
      chk(d, "ula_b_rst", ub[d], 0);
      chk(d, "ula_op_rst", uop[d], 0);
      chk(d, "resp_result_rst", rres[d], 0);
    end else begin
      chk(d, "ula_a", ua[d], ea[d]);
      chk(d, "ula_b", ub[d], eb[d]);
      chk(d, "ula_op", uop[d], eo[d]);
    end
    if (rst[d] && (rdy[d] & rv[d]) != 0) obs_acc[d] = cyc;
    if (rst[d] && er != 0 && rr[d][own[d]])
      lg.push_back('{d, rsv[d][1] ? 1 : 0, rres[d], obs_acc[d], cyc});
  endtask

  task automatic update(int d);
    logic [1:0] g;
    int i;
    if (!rst[d]) begin
      infl[d] = 0; fresh[d] = 1; last[d] = 1;
    end else if (!infl[d]) begin
      g = grant(rv[d], last[d]);
      if (g != 0) begin
        i = g[1] ? 1 : 0;
        infl[d] = 1; acc[d] = cyc; own[d] = i; last[d] = i; fresh[d] = 0;
        ea[d] = ra[d][i*W +: W];
        eb[d] = rb[d][i*W +: W];
        eo[d] = rop[d][i*2 +: 2];
        ev[d] = ea[d] + eb[d];
      end
    end else if (exp_resp(d) != 0 && rr[d][own[d]]) begin
      infl[d] = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_dut(d);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) update(d);
    cyc++;
  endtask

  task automatic wait_log(int n, int budget);
    int b = 0;
    while (lg.size() < n && b < budget) begin step(); b++; end
    chk(-1, "log_count", lg.size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst = 2'b00; rv = '0; rr = '0; ra = '0; rb = '0; rop = '0;
    for (int d = 0; d < 2; d++) begin
      infl[d] = 0; fresh[d] = 1; last[d] = 1; obs_acc[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 2'b11;

    // Single request on the latency-1 instance: 5+3.
    lg.delete();
    rr[0] = 2'b01; ra[0] = {32'd0, 32'd5}; rb[0] = {32'd0, 32'd3}; rop[0] = 4'b0110;
    rv[0] = 2'b01;
    step();
    rv[0] = 2'b00;
    wait_log(1, 20);
    if (lg.size() >= 1) begin
      chk(0, "t1_res", lg[0].res, 8);
      chk(0, "t1_own", lg[0].own, 0);
      chk(0, "t1_lat", lg[0].done - lg[0].acc, 2);
    end

    // Fresh reset, then both requesters held valid for four operations.
    rst[0] = 1'b0; step(); rst[0] = 1'b1;
    lg.delete();
    ra[0] = {32'd2, 32'd1}; rb[0] = {32'd2, 32'd1}; rv[0] = 2'b11; rr[0] = 2'b11;
    wait_log(4, 40);
    rv[0] = 2'b00;
    for (int k = 0; k < 4 && k < lg.size(); k++) begin
      chk(0, "rr_own", lg[k].own, k % 2);
      chk(0, "rr_res", lg[k].res, (k % 2) ? 4 : 2);
      if (k > 0) chk(0, "rr_period", lg[k].acc - lg[k-1].acc, 3);
    end

    // Response stall: owner withholds resp_ready, non-owner's ready is ignored.
    lg.delete();
    rr[0] = 2'b10; ra[0] = {32'd0, 32'd5}; rb[0] = {32'd0, 32'd3}; rv[0] = 2'b01;
    step();
    rv[0] = 2'b10; ra[0] = {32'd20, 32'd0}; rb[0] = {32'd1, 32'd0};
    b = 0;
    while (rsv[0] == 2'b00 && b < 10) begin step(); b++; end
    chk(0, "stall_wait", rsv[0], 2'b01);
    repeat (5) begin
      chk(0, "stall_res", rres[0], 8);
      chk(0, "stall_valid", rsv[0], 2'b01);
      chk(0, "stall_ready", rdy[0], 2'b00);
      step();
    end
    rr[0] = 2'b01;
    step();
    chk(0, "stall_idle", bsy[0], 0);
    rr[0] = 2'b11;
    wait_log(2, 20);
    rv[0] = 2'b00;
    if (lg.size() >= 2) begin
      chk(0, "stall_res0", lg[0].res, 8);
      chk(0, "next_own", lg[1].own, 1);
      chk(0, "next_res", lg[1].res, 21);
    end

    // Latency-3 instance: 32-bit wrap-around.
    lg.delete();
    rr[1] = 2'b01; ra[1] = {32'd0, 32'hFFFF_FFFF}; rb[1] = {32'd0, 32'd1}; rv[1] = 2'b01;
    step();
    rv[1] = 2'b00; ra[1] = {$urandom, $urandom}; rb[1] = {$urandom, $urandom};
    wait_log(1, 20);
    if (lg.size() >= 1) begin
      chk(1, "wrap_res", lg[0].res, 0);
      chk(1, "wrap_lat", lg[0].done - lg[0].acc, 4);
    end

    // Reset one edge after accept: operation is dropped, next request served normally.
    lg.delete();
    ra[1] = {32'd0, 32'd7}; rb[1] = {32'd0, 32'd7}; rv[1] = 2'b01;
    step();
    rv[1] = 2'b00; rst[1] = 1'b0;
    step();
    rst[1] = 1'b1;
    chk(1, "abort_valid", rsv[1], 0);
    chk(1, "abort_busy", bsy[1], 0);
    chk(1, "abort_ula_a", ua[1], 0);
    chk(1, "abort_res", rres[1], 0);
    ra[1] = {32'd9, 32'd0}; rb[1] = {32'd1, 32'd0}; rv[1] = 2'b10; rr[1] = 2'b10;
    step();
    rv[1] = 2'b00;
    wait_log(1, 20);
    repeat (4) step();
    chk(1, "abort_count", lg.size(), 1);
    if (lg.size() >= 1) begin
      chk(1, "abort_own", lg[0].own, 1);
      chk(1, "abort_next", lg[0].res, 10);
    end

    // Random traffic on both instances, with occasional resets.
    repeat (800) begin
      for (int d = 0; d < 2; d++) begin
        rst[d] = ($urandom_range(0, 99) != 0);
        rv[d]  = 2'($urandom);
        ra[d]  = {$urandom, $urandom};
        rb[d]  = {$urandom, $urandom};
        rop[d] = 4'($urandom);
        rr[d]  = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
